// File: rtl/flag_branch_unit.sv
// Flag register plus conditional branch resolver; one result per accepted branch.
// Latency: 1 cycle from acceptance to res_valid.
// Backpressure: br_ready drops while a flag write is in flight this cycle.
module flag_branch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flag_v,
    input  logic        flag_n,
    input  logic        flag_z,
    input  logic        wr_all,
    input  logic        wr_z,
    input  logic        br_valid,
    input  logic [2:0]  br_cond,
    input  logic [15:0] br_pc,
    input  logic [8:0]  br_off,
    input  logic        flush,
    output logic        br_ready,
    output logic        res_valid,
    output logic        taken,
    output logic [15:0] next_pc,
    output logic [2:0]  flags
);
    typedef enum logic [2:0] {
        C_NEQ = 3'b000, C_EQ  = 3'b001, C_GT   = 3'b010, C_LT     = 3'b011,
        C_GTE = 3'b100, C_LTE = 3'b101, C_OVFL = 3'b110, C_UNCOND = 3'b111
    } cond_e;

    logic        z_q, v_q, n_q;
    logic        z_d, v_d, n_d;
    logic        res_valid_q, res_valid_d;
    logic        taken_q, taken_d;
    logic [15:0] next_pc_q, next_pc_d;
    logic        cond_met;
    logic        accept;
    logic [15:0] seq_pc;
    logic [15:0] tgt_pc;

    // A flag write this cycle makes the registered flags stale for a branch.
    assign br_ready = ~(wr_all | wr_z);
    assign accept   = br_valid & br_ready;

    always_comb begin
        cond_met = 1'b0;
        case (cond_e'(br_cond))
            C_NEQ:    cond_met = ~z_q;
            C_EQ:     cond_met = z_q;
            C_GT:     cond_met = ~z_q & ~n_q;
            C_LT:     cond_met = n_q;
            C_GTE:    cond_met = z_q | ~n_q;
            C_LTE:    cond_met = z_q | n_q;
            C_OVFL:   cond_met = v_q;
            C_UNCOND: cond_met = 1'b1;
            default:  cond_met = 1'b0;
        endcase
    end

    assign seq_pc = br_pc + 16'd1;
    assign tgt_pc = seq_pc + {{7{br_off[8]}}, br_off};

    always_comb begin
        z_d = z_q;
        v_d = v_q;
        n_d = n_q;
        if (wr_all) begin
            z_d = flag_z;
            v_d = flag_v;
            n_d = flag_n;
        end else if (wr_z) begin
            z_d = flag_z;
        end
    end

    // A flushed acceptance is discarded entirely, so taken/next_pc hold too.
    always_comb begin
        res_valid_d = accept & ~flush;
        taken_d     = taken_q;
        next_pc_d   = next_pc_q;
        if (accept && !flush) begin
            taken_d   = cond_met;
            next_pc_d = cond_met ? tgt_pc : seq_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q         <= 1'b0;
            v_q         <= 1'b0;
            n_q         <= 1'b0;
            res_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            next_pc_q   <= 16'h0000;
        end else begin
            z_q         <= z_d;
            v_q         <= v_d;
            n_q         <= n_d;
            res_valid_q <= res_valid_d;
            taken_q     <= taken_d;
            next_pc_q   <= next_pc_d;
        end
    end

    assign res_valid = res_valid_q;
    assign taken     = taken_q;
    assign next_pc   = next_pc_q;
    assign flags     = {z_q, v_q, n_q};
endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed and randomized checks of flag_branch_unit against a behavioural model.
module tb_flag_branch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flag_v, flag_n, flag_z;
    logic        wr_all, wr_z;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [15:0] br_pc;
    logic [8:0]  br_off;
    logic        flush;
    logic        br_ready, res_valid, taken;
    logic [15:0] next_pc;
    logic [2:0]  flags;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    bit m_z, m_v, m_n;
    bit m_res;
    bit m_taken;
    int m_pc;

    flag_branch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .flag_v(flag_v), .flag_n(flag_n), .flag_z(flag_z),
        .wr_all(wr_all), .wr_z(wr_z),
        .br_valid(br_valid), .br_cond(br_cond), .br_pc(br_pc), .br_off(br_off),
        .flush(flush),
        .br_ready(br_ready), .res_valid(res_valid), .taken(taken),
        .next_pc(next_pc), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_true(input int c, input bit z, input bit v, input bit n);
        bit r;
        r = 0;
        if (c == 0) r = !z;
        if (c == 1) r = z;
        if (c == 2) r = !z && !n;
        if (c == 3) r = n;
        if (c == 4) r = z || !n;
        if (c == 5) r = z || n;
        if (c == 6) r = v;
        if (c == 7) r = 1;
        return r;
    endfunction

    function automatic int target(input int pc, input int off9, input bit tk);
        int off;
        off = (off9 >= 256) ? off9 - 512 : off9;
        return tk ? ((pc + 1 + off) % 65536 + 65536) % 65536 : (pc + 1) % 65536;
    endfunction

    task automatic model_reset();
        m_z = 0; m_v = 0; m_n = 0; m_res = 0; m_taken = 0; m_pc = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".res_valid"}, {31'd0, res_valid}, {31'd0, m_res});
        chk({tag, ".taken"}, {31'd0, taken}, {31'd0, m_taken});
        chk({tag, ".next_pc"}, {16'd0, next_pc}, m_pc);
        chk({tag, ".flags"}, {29'd0, flags}, {29'd0, m_z, m_v, m_n});
    endtask

    // Apply one cycle of inputs, check ready, clock, then check registered outputs.
    task automatic step(input string tag, input bit wa, input bit wz, input bit fv, input bit fn,
                        input bit fz, input bit bv, input int cond, input int pc,
                        input int off, input bit fl);
        bit rdy, acc, tk;
        wr_all = wa; wr_z = wz; flag_v = fv; flag_n = fn; flag_z = fz;
        br_valid = bv; br_cond = 3'(cond); br_pc = 16'(pc); br_off = 9'(off); flush = fl;
        #1;
        rdy = !(wa || wz);
        chk({tag, ".br_ready"}, {31'd0, br_ready}, {31'd0, rdy});
        acc = bv && rdy;
        tk  = cond_true(cond, m_z, m_v, m_n);
        if (acc && !fl) begin
            m_taken = tk;
            m_pc    = target(pc, off, tk);
        end
        m_res = acc && !fl;
        if (wa) begin
            m_z = fz; m_v = fv; m_n = fn;
        end else if (wz) begin
            m_z = fz;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst_n = 0;
        {flag_v, flag_n, flag_z, wr_all, wr_z, br_valid, flush} = '0;
        br_cond = 0; br_pc = 0; br_off = 0;
        model_reset();
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Flags drive LT
        step("wrall", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("wrall.flags_const", {29'd0, flags}, 32'b001);
        step("lt", 0, 0, 0, 0, 0, 1, 3, 16'h0010, 9'h005, 0);
        chk("lt.res_const", {31'd0, res_valid}, 1);
        chk("lt.taken_const", {31'd0, taken}, 1);
        chk("lt.pc_const", {16'd0, next_pc}, 32'h0016);

        // Hazard: Z write stalls EQ, then it sees Z=1
        step("haz0", 0, 1, 0, 0, 1, 1, 1, 16'h0100, 9'h010, 0);
        chk("haz0.res_const", {31'd0, res_valid}, 0);
        step("haz1", 0, 0, 0, 0, 0, 1, 1, 16'h0100, 9'h010, 0);
        chk("haz1.taken_const", {31'd0, taken}, 1);
        chk("haz1.pc_const", {16'd0, next_pc}, 32'h0111);

        // Wrap with -1 offset, then not-taken wrap
        step("wrap_t", 0, 0, 0, 0, 0, 1, 7, 16'hFFFF, 9'h1FF, 0);
        chk("wrap_t.pc_const", {16'd0, next_pc}, 32'hFFFF);
        step("wrap_n", 0, 0, 0, 0, 0, 1, 6, 16'hFFFF, 9'h1FF, 0);
        chk("wrap_n.pc_const", {16'd0, next_pc}, 32'h0000);
        chk("wrap_n.taken_const", {31'd0, taken}, 0);

        // Partial and combined flag writes
        step("part0", 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        step("part1", 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("part1.flags_const", {29'd0, flags}, 32'b111);
        step("both", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("both.flags_const", {29'd0, flags}, 32'b001);

        // Back-to-back results, then flush on an accepting cycle
        step("b2b0", 0, 0, 0, 0, 0, 1, 7, 16'h2000, 9'h100, 0);
        step("b2b1", 0, 0, 0, 0, 0, 1, 0, 16'h3000, 9'h003, 0);
        step("flush", 0, 0, 0, 0, 0, 1, 7, 16'h4000, 9'h004, 1);
        chk("flush.res_const", {31'd0, res_valid}, 0);

        // Reset mid-stream without a clock edge
        step("pre_rst", 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        step("pre_rst2", 0, 0, 0, 0, 0, 1, 7, 16'h1234, 9'h011, 0);
        wr_all = 1; flag_v = 1; flag_n = 1; flag_z = 1; br_valid = 1; br_cond = 7;
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        @(negedge clk);
        rst_n = 1;
        step("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            bit wa, wz, bv, fl;
            wa = ($urandom_range(0, 99) < 20);
            wz = ($urandom_range(0, 99) < 20);
            bv = ($urandom_range(0, 99) < 75);
            fl = ($urandom_range(0, 99) < 10);
            step("rand", wa, wz, 1'($urandom), 1'($urandom), 1'($urandom), bv,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 511)), fl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
